// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports.
// One command in flight at a time; completion is a one-cycle valid pulse per port.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     state;
  logic       owner_dm;
  logic       lat_we;
  logic [2:0] cnt;
  logic [1:0] skip_cnt;
  logic       grant_any;
  logic       grant_dm;

  // Data port wins contention until fetch has been passed over twice.
  always_comb begin
    grant_any = if_req | dm_req;
    if (if_req && dm_req) grant_dm = (skip_cnt != 2'd2);
    else                  grant_dm = dm_req;
  end

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  // Command fields are captured straight into the mem_* registers at the
  // arbitration edge, so they are valid in ISSUE and hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      skip_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (grant_any) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            owner_dm <= grant_dm;
            lat_we   <= grant_dm & dm_we;
            mem_en   <= 1'b1;
            mem_we   <= grant_dm & dm_we;
            mem_addr <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) begin
              mem_wdata <= dm_wdata;
              mem_be    <= dm_be;
              if (if_req && skip_cnt != 2'd2) skip_cnt <= skip_cnt + 2'd1;
            end else begin
              skip_cnt <= '0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= 3'd1;
        end
        WAIT: begin
          if (cnt == LAT) begin
            state <= DONE;
            if (owner_dm) begin
              dm_valid <= 1'b1;
              if (!lat_we) dm_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance,
// each backed by a small latency-accurate memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int          nerr = 0;
  int          nchk = 0;

  always #5 clk = ~clk;

  // MEM_LAT = 2 instance
  logic        if_req, if_valid, if_stall, dm_req, dm_we, dm_valid, dm_stall;
  logic        mem_en, mem_we, busy;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  dm_be, mem_be;

  // MEM_LAT = 1 instance
  logic        b_if_req, b_if_valid, b_if_stall, b_dm_req, b_dm_we, b_dm_valid, b_dm_stall;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_dm_be, b_mem_be;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid), .if_stall(b_if_stall),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata), .dm_be(b_dm_be),
    .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid), .dm_stall(b_dm_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h100: return 32'h00A00713;
      32'h200: return 32'h11223344;
      default: return a ^ 32'hA5A50000;
    endcase
  endfunction

  // Memory model: data valid only in cycle issue+MEM_LAT, junk otherwise; ignores reset.
  logic       armed0 = 1'b0, armed1 = 1'b0;
  logic [2:0] cd0 = '0;
  logic [31:0] rda0 = '0, rda1 = '0;

  always @(posedge clk) begin
    if (mem_en) begin rda0 <= mem_addr; cd0 <= 3'd1; armed0 <= 1'b1; end
    else if (armed0 && cd0 != 3'd0) cd0 <= cd0 - 3'd1;
    else armed0 <= 1'b0;
    if (b_mem_en) begin rda1 <= b_mem_addr; armed1 <= 1'b1; end
    else armed1 <= 1'b0;
  end

  assign mem_rdata   = (armed0 && cd0 == 3'd0) ? memfn(rda0) : 32'hBAD0BAD0;
  assign b_mem_rdata = armed1 ? memfn(rda1) : 32'hBAD1BAD1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    if_req = 1'b1; dm_req = 1'b1; #1;
    nchk++; if (if_stall !== 1'b1) begin $display("FAIL rst.if_stall got %b want 1", if_stall); nerr++; end
    nchk++; if (dm_stall !== 1'b1) begin $display("FAIL rst.dm_stall got %b want 1", dm_stall); nerr++; end
    nchk++; if ({mem_en, mem_we, busy, if_valid, dm_valid} !== 5'b0) begin $display("FAIL rst.ctl got %b want 00000", {mem_en, mem_we, busy, if_valid, dm_valid}); nerr++; end
    nchk++; if ({mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata} !== '0) begin $display("FAIL rst.data got %h want 0", {mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata}); nerr++; end
    step();
    nchk++; if (mem_en !== 1'b0) begin $display("FAIL rst.mem_en_held got %b want 0", mem_en); nerr++; end
    if_req = 1'b0; dm_req = 1'b0; reset = 1'b0;
    step();
    nchk++; if (busy !== 1'b0) begin $display("FAIL rst.busy_after got %b want 0", busy); nerr++; end
  endtask

  task automatic test_single_fetch();
    if_addr = 32'h100; if_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) step(); else #1;
      nchk++; if (mem_en !== (c == 1)) begin $display("FAIL fetch.mem_en c%0d got %b want %b", c, mem_en, c == 1); nerr++; end
      nchk++; if (mem_we !== 1'b0) begin $display("FAIL fetch.mem_we c%0d got %b want 0", c, mem_we); nerr++; end
      nchk++; if (if_valid !== (c == 4)) begin $display("FAIL fetch.if_valid c%0d got %b want %b", c, if_valid, c == 4); nerr++; end
      nchk++; if (if_stall !== (c <= 3)) begin $display("FAIL fetch.if_stall c%0d got %b want %b", c, if_stall, c <= 3); nerr++; end
      nchk++; if (busy !== (c >= 1 && c <= 4)) begin $display("FAIL fetch.busy c%0d got %b want %b", c, busy, c >= 1 && c <= 4); nerr++; end
      if (c == 1) begin
        nchk++; if (mem_addr !== 32'h100) begin $display("FAIL fetch.mem_addr got %h want 00000100", mem_addr); nerr++; end
      end
      if (c >= 4) begin
        nchk++; if (if_rdata !== 32'h00A00713) begin $display("FAIL fetch.if_rdata c%0d got %h want 00a00713", c, if_rdata); nerr++; end
      end
      if (c == 4) if_req = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    if_addr = 32'h100; if_req = 1'b1;
    dm_addr = 32'h200; dm_we = 1'b0; dm_req = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) step(); else #1;
      nchk++; if (mem_en !== (c == 1 || c == 5)) begin $display("FAIL sim.mem_en c%0d got %b want %b", c, mem_en, c == 1 || c == 5); nerr++; end
      nchk++; if (dm_valid !== (c == 4)) begin $display("FAIL sim.dm_valid c%0d got %b want %b", c, dm_valid, c == 4); nerr++; end
      nchk++; if (if_valid !== (c == 8)) begin $display("FAIL sim.if_valid c%0d got %b want %b", c, if_valid, c == 8); nerr++; end
      nchk++; if (if_stall !== (c <= 7)) begin $display("FAIL sim.if_stall c%0d got %b want %b", c, if_stall, c <= 7); nerr++; end
      nchk++; if (dm_stall !== (c <= 3)) begin $display("FAIL sim.dm_stall c%0d got %b want %b", c, dm_stall, c <= 3); nerr++; end
      if (c == 1) begin
        nchk++; if (mem_addr !== 32'h200) begin $display("FAIL sim.addr_dm got %h want 00000200", mem_addr); nerr++; end
      end
      if (c == 5) begin
        nchk++; if (mem_addr !== 32'h100) begin $display("FAIL sim.addr_if got %h want 00000100", mem_addr); nerr++; end
      end
      if (c == 4) begin
        nchk++; if (dm_rdata !== 32'h11223344) begin $display("FAIL sim.dm_rdata got %h want 11223344", dm_rdata); nerr++; end
        dm_req = 1'b0;
      end
      if (c == 8) begin
        nchk++; if (if_rdata !== 32'h00A00713) begin $display("FAIL sim.if_rdata got %h want 00a00713", if_rdata); nerr++; end
        if_req = 1'b0;
      end
      if (c == 9) begin
        nchk++; if (busy !== 1'b0) begin $display("FAIL sim.busy_end got %b want 0", busy); nerr++; end
      end
    end
  endtask

  task automatic test_write();
    dm_addr = 32'h200; dm_we = 1'b1; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF; dm_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) step(); else #1;
      nchk++; if (mem_we !== (c == 1)) begin $display("FAIL wr.mem_we c%0d got %b want %b", c, mem_we, c == 1); nerr++; end
      nchk++; if (dm_valid !== (c == 4)) begin $display("FAIL wr.dm_valid c%0d got %b want %b", c, dm_valid, c == 4); nerr++; end
      if (c == 1) begin
        nchk++; if ({mem_en, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h200, 32'hDEADBEEF, 4'hF}) begin
          $display("FAIL wr.cmd got en=%b a=%h d=%h be=%h want en=1 a=00000200 d=deadbeef be=f", mem_en, mem_addr, mem_wdata, mem_be); nerr++; end
      end
      if (c >= 4) begin
        nchk++; if (dm_rdata !== 32'h11223344) begin $display("FAIL wr.dm_rdata_kept c%0d got %h want 11223344", c, dm_rdata); nerr++; end
      end
      if (c == 4) begin dm_req = 1'b0; dm_we = 1'b0; end
    end
  endtask

  task automatic test_starvation();
    logic [7:0] got [6];
    logic [7:0] want [6];
    int g, cyc, last;
    logic seen;
    want = '{"D", "D", "F", "D", "D", "F"};
    g = 0; cyc = 0; last = 0;
    if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0; if_req = 1'b1; dm_req = 1'b1;
    #1;
    while (g < 6 && cyc < 60) begin
      if (mem_en) begin
        got[g] = (mem_addr == 32'h200) ? 8'h44 : 8'h46;
        if (g > 0) begin
          nchk++; if (cyc - last != 4) begin $display("FAIL starve.spacing g%0d got %0d want 4", g, cyc - last); nerr++; end
        end
        last = cyc; g++;
      end
      if (g < 6) begin step(); cyc++; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    nchk++; if (g != 6) begin $display("FAIL starve.count got %0d want 6", g); nerr++; end
    for (int i = 0; i < g; i++) begin
      nchk++; if (got[i] !== want[i]) begin $display("FAIL starve.order g%0d got %c want %c", i, got[i], want[i]); nerr++; end
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin step(); if (if_valid) seen = 1'b1; end
    nchk++; if (!seen) begin $display("FAIL starve.withdrawn_valid got 0 want 1"); nerr++; end
    step();
    nchk++; if (busy !== 1'b0) begin $display("FAIL starve.busy_end got %b want 0", busy); nerr++; end
  endtask

  task automatic test_reset_midwait();
    if_addr = 32'h100; if_req = 1'b1;
    step();
    nchk++; if (mem_en !== 1'b1) begin $display("FAIL rstw.issue got %b want 1", mem_en); nerr++; end
    step();
    reset = 1'b1; #1;
    nchk++; if ({mem_en, mem_we, busy, if_valid, dm_valid} !== 5'b0) begin $display("FAIL rstw.ctl got %b want 00000", {mem_en, mem_we, busy, if_valid, dm_valid}); nerr++; end
    nchk++; if ({mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata} !== '0) begin $display("FAIL rstw.data got %h want 0", {mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata}); nerr++; end
    nchk++; if (if_stall !== 1'b1) begin $display("FAIL rstw.if_stall got %b want 1", if_stall); nerr++; end
    if_req = 1'b0;
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      nchk++; if ({if_valid, busy} !== 2'b00) begin $display("FAIL rstw.quiet c%0d got %b want 00", c, {if_valid, busy}); nerr++; end
    end
    if_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) step(); else #1;
      nchk++; if (mem_en !== (c == 1)) begin $display("FAIL rstw.refetch_en c%0d got %b want %b", c, mem_en, c == 1); nerr++; end
      nchk++; if (if_valid !== (c == 4)) begin $display("FAIL rstw.refetch_valid c%0d got %b want %b", c, if_valid, c == 4); nerr++; end
      if (c == 4) begin
        nchk++; if (if_rdata !== 32'h00A00713) begin $display("FAIL rstw.refetch_data got %h want 00a00713", if_rdata); nerr++; end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_memlat1();
    b_dm_addr = 32'h200; b_dm_we = 1'b0; b_dm_req = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) step(); else #1;
      nchk++; if (b_mem_en !== (c == 1 || c == 4)) begin $display("FAIL lat1.mem_en c%0d got %b want %b", c, b_mem_en, c == 1 || c == 4); nerr++; end
      nchk++; if (b_dm_valid !== (c == 3 || c == 6)) begin $display("FAIL lat1.dm_valid c%0d got %b want %b", c, b_dm_valid, c == 3 || c == 6); nerr++; end
      if (c == 4) begin
        nchk++; if (b_mem_addr !== 32'h204) begin $display("FAIL lat1.addr2 got %h want 00000204", b_mem_addr); nerr++; end
      end
      if (c == 3) begin
        nchk++; if (b_dm_rdata !== 32'h11223344) begin $display("FAIL lat1.rdata1 got %h want 11223344", b_dm_rdata); nerr++; end
        b_dm_addr = 32'h204;
      end
      if (c == 6) begin
        nchk++; if (b_dm_rdata !== 32'hA5A50204) begin $display("FAIL lat1.rdata2 got %h want a5a50204", b_dm_rdata); nerr++; end
        b_dm_req = 1'b0;
      end
      if (c == 7) begin
        nchk++; if (b_busy !== 1'b0) begin $display("FAIL lat1.busy_end got %b want 0", b_busy); nerr++; end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0; b_dm_be = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_write();
    test_starvation();
    test_reset_midwait();
    test_memlat1();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
